// File: rtl/axi_package.sv
// rtl/axi_package.sv - host register widths, command codes and status codes
package axi_package;

  localparam int REG_WIDTH    = 32;
  localparam int STATUS_WIDTH = 3;

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ               = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd4;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

  localparam logic [STATUS_WIDTH-1:0] STATUS_IDLE     = 3'd0;
  localparam logic [STATUS_WIDTH-1:0] STATUS_RUNNING  = 3'd1;
  localparam logic [STATUS_WIDTH-1:0] STATUS_ACCEPTED = 3'd2;
  localparam logic [STATUS_WIDTH-1:0] STATUS_REJECTED = 3'd3;
  localparam logic [STATUS_WIDTH-1:0] STATUS_ERROR    = 3'd4;

endpackage

// File: rtl/instruction_package.sv
// rtl/instruction_package.sv - regex instruction format and opcodes
package instruction_package;

  localparam int INSTRUCTION_WIDTH = 16;
  localparam int OPCODE_MSB        = 15;
  localparam int OPCODE_LSB        = 13;
  localparam int OPERAND_WIDTH     = 13;
  localparam int CHAR_WIDTH        = 8;

  typedef enum logic [2:0] {
    OP_ACCEPT                = 3'd0,
    OP_SPLIT                 = 3'd1,
    OP_MATCH                 = 3'd2,
    OP_JMP                   = 3'd3,
    OP_END_WITHOUT_ACCEPTING = 3'd4,
    OP_MATCH_ANY             = 3'd5,
    OP_ACCEPT_PARTIAL        = 3'd6,
    OP_NOT_MATCH             = 3'd7
  } opcode_t;

endpackage

// File: rtl/regex_engine.sv
// rtl/regex_engine.sv - backtracking regex engine: FSM, thread stack, elapsed counter
// Ports: clk, rst (sync, active-high); start/abort command strobes;
//        start_cc/end_cc string bounds (byte addresses, end inclusive);
//        inst_addr/char_addr word indices issued to memory, inst_word/char_word
//        the registered words returned one cycle later; status, elapsed.
module regex_engine
  import axi_package::*;
  import instruction_package::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int ADDR_WIDTH  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [REG_WIDTH-1:0]    start_cc,
  input  logic [REG_WIDTH-1:0]    end_cc,
  input  logic [REG_WIDTH-1:0]    inst_word,
  input  logic [REG_WIDTH-1:0]    char_word,
  output logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [ADDR_WIDTH-1:0]   char_addr,
  output logic [STATUS_WIDTH-1:0] status,
  output logic [REG_WIDTH-1:0]    elapsed
);

  localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_WIDTH = $clog2(STACK_DEPTH);
  localparam logic [SP_WIDTH-1:0]      SP_ONE = 1;
  localparam logic [OPERAND_WIDTH-1:0] PC_ONE = 1;
  localparam logic [REG_WIDTH-1:0]     CC_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_ACCEPTED, S_REJECTED, S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0]     cc_q, cc_d;
  logic [SP_WIDTH-1:0]      sp_q, sp_d;
  logic                     push, fail, clear_count;

  logic [OPERAND_WIDTH-1:0] stack_pc [STACK_DEPTH];
  logic [REG_WIDTH-1:0]     stack_cc [STACK_DEPTH];

  logic [INSTRUCTION_WIDTH-1:0] instr;
  opcode_t                      opcode;
  logic [OPERAND_WIDTH-1:0]     operand;
  logic [CHAR_WIDTH-1:0]        str_byte;
  logic                         in_range, stack_full;
  logic [IDX_WIDTH-1:0]         top_idx, push_idx;

  // pc is a halfword index, cc a byte index, both into the shared word memory.
  assign inst_addr = pc_q[ADDR_WIDTH:1];
  assign char_addr = cc_q[ADDR_WIDTH+1:2];

  assign instr   = pc_q[0] ? inst_word[31:16] : inst_word[15:0];
  assign opcode  = opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
  assign operand = instr[OPERAND_WIDTH-1:0];

  always_comb begin
    str_byte = char_word[7:0];
    case (cc_q[1:0])
      2'd1:    str_byte = char_word[15:8];
      2'd2:    str_byte = char_word[23:16];
      2'd3:    str_byte = char_word[31:24];
      default: str_byte = char_word[7:0];
    endcase
  end

  assign in_range   = (cc_q <= end_cc);
  assign stack_full = (sp_q == SP_WIDTH'(STACK_DEPTH));
  assign top_idx    = IDX_WIDTH'(sp_q - SP_ONE);
  assign push_idx   = IDX_WIDTH'(sp_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cc_d        = cc_q;
    sp_d        = sp_q;
    push        = 1'b0;
    fail        = 1'b0;
    clear_count = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d        = '0;
          cc_d        = start_cc;
          sp_d        = '0;
          clear_count = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ACCEPT: begin
            if (!in_range) state_d = S_ACCEPTED;
            else           fail = 1'b1;
          end
          OP_SPLIT: begin
            if (stack_full) begin
              state_d = S_ERROR;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_ONE;
              pc_d = pc_q + PC_ONE;
            end
          end
          OP_MATCH, OP_NOT_MATCH: begin
            // NOT_MATCH differs only in the sense of the character test
            if (in_range && ((str_byte == operand[CHAR_WIDTH-1:0]) == (opcode == OP_MATCH))) begin
              pc_d = pc_q + PC_ONE;
              cc_d = cc_q + CC_ONE;
            end else begin
              fail = 1'b1;
            end
          end
          OP_JMP: pc_d = operand;
          OP_MATCH_ANY: begin
            if (in_range) begin
              pc_d = pc_q + PC_ONE;
              cc_d = cc_q + CC_ONE;
            end else begin
              fail = 1'b1;
            end
          end
          OP_ACCEPT_PARTIAL: state_d = S_ACCEPTED;
          default: fail = 1'b1;
        endcase
        // A failed thread resumes the most recent alternative in the same cycle.
        if (fail) begin
          if (sp_q != '0) begin
            pc_d = stack_pc[top_idx];
            cc_d = stack_cc[top_idx];
            sp_d = sp_q - SP_ONE;
          end else begin
            state_d = S_REJECTED;
          end
        end
      end
      default: ;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cc_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack_pc[push_idx] <= operand;
      stack_cc[push_idx] <= cc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_count) elapsed <= '0;
    else if (state_q == S_FETCH || state_q == S_EXEC) elapsed <= elapsed + CC_ONE;
  end

  always_comb begin
    status = STATUS_IDLE;
    case (state_q)
      S_FETCH, S_EXEC: status = STATUS_RUNNING;
      S_ACCEPTED:      status = STATUS_ACCEPTED;
      S_REJECTED:      status = STATUS_REJECTED;
      S_ERROR:         status = STATUS_ERROR;
      default:         status = STATUS_IDLE;
    endcase
  end

endmodule

// File: rtl/axi_top.sv
// rtl/axi_top.sv - regex coprocessor top: shared program/string memory and command decode
// Ports: clk, rst (sync, active-high); data_in_register write data;
//        address_register word index; start/end_cc_pointer_register string bounds;
//        cmd_register command code; status_register engine status (zero-extended);
//        data_o_register read or elapsed-clock result.
module axi_top
  import axi_package::*;
#(
  parameter int MEM_WORDS   = 512,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] data_in_register,
  input  logic [REG_WIDTH-1:0] address_register,
  input  logic [REG_WIDTH-1:0] start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] cmd_register,
  output logic [REG_WIDTH-1:0] status_register,
  output logic [REG_WIDTH-1:0] data_o_register
);

  localparam int ADDR_WIDTH = $clog2(MEM_WORDS);

  logic [REG_WIDTH-1:0]    mem [MEM_WORDS];
  logic [REG_WIDTH-1:0]    mem_q, inst_q, char_q, elapsed;
  logic [ADDR_WIDTH-1:0]   host_addr, inst_addr, char_addr;
  logic [STATUS_WIDTH-1:0] engine_status;
  logic                    running;
  logic                    unused_addr_bits;

  assign host_addr        = address_register[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^address_register[REG_WIDTH-1:ADDR_WIDTH];
  assign running          = (engine_status == STATUS_RUNNING);

  // Host port plus the engine's instruction and character ports, all registered.
  always_ff @(posedge clk) begin
    if (cmd_register == CMD_WRITE && !running) mem[host_addr] <= data_in_register;
    mem_q  <= mem[host_addr];
    inst_q <= mem[inst_addr];
    char_q <= mem[char_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o_register <= '0;
    end else if (cmd_register == CMD_READ && !running) begin
      data_o_register <= mem_q;
    end else if (cmd_register == CMD_READ_ELAPSED_CLOCK) begin
      data_o_register <= elapsed;
    end
  end

  regex_engine #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (cmd_register == CMD_START),
    .abort     (cmd_register == CMD_RESET),
    .start_cc  (start_cc_pointer_register),
    .end_cc    (end_cc_pointer_register),
    .inst_word (inst_q),
    .char_word (char_q),
    .inst_addr (inst_addr),
    .char_addr (char_addr),
    .status    (engine_status),
    .elapsed   (elapsed)
  );

  assign status_register = {{(REG_WIDTH-STATUS_WIDTH){1'b0}}, engine_status};

endmodule

// File: tb/tb_axi_top.sv
// tb/tb_axi_top.sv - directed self-checking bench for axi_top
module tb_axi_top;

  localparam logic [31:0] C_NOP = 0, C_WRITE = 1, C_READ = 2, C_START = 3, C_RESET = 4, C_ELAPSED = 5;
  localparam logic [31:0] ST_IDLE = 0, ST_RUN = 1, ST_ACC = 2, ST_REJ = 3, ST_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in_register = 0, address_register = 0;
  logic [31:0] start_cc_pointer_register = 0, end_cc_pointer_register = 0;
  logic [31:0] cmd_register = 0;
  logic [31:0] status_register, data_o_register;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] blk [0:15];

  axi_top dut (
    .clk                       (clk),
    .rst                       (rst),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_block(input int base, input int n);
    cmd_register = C_WRITE;
    for (int i = 0; i < n; i++) begin
      address_register = base + i;
      data_in_register = blk[i];
      tick();
    end
    cmd_register = C_NOP;
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    cmd_register = C_READ;
    address_register = a;
    tick();
    tick();
    d = data_o_register;
    cmd_register = C_NOP;
  endtask

  task automatic read_elapsed(output logic [31:0] d);
    cmd_register = C_ELAPSED;
    tick();
    d = data_o_register;
    cmd_register = C_NOP;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] e, output logic [31:0] st);
    start_cc_pointer_register = s;
    end_cc_pointer_register = e;
    cmd_register = C_START;
    tick();
    cmd_register = C_NOP;
    st = status_register;
  endtask

  task automatic wait_done(output logic [31:0] st);
    for (int i = 0; i < 1000 && status_register == ST_RUN; i++) tick();
    st = status_register;
  endtask

  task automatic soft_reset;
    cmd_register = C_RESET;
    tick();
    cmd_register = C_NOP;
  endtask

  task automatic load_regex_program;
    // 0 MATCH a; 1 SPLIT 7; 2 SPLIT 5; 3 MATCH b; 4 JMP 1; 5 MATCH c; 6 JMP 1; 7 ACCEPT
    blk[0] = 32'h2007_4061;
    blk[1] = 32'h4062_2005;
    blk[2] = 32'h4063_6001;
    blk[3] = 32'h0000_6001;
    write_block(0, 4);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (status_register !== ST_IDLE) begin miscompares++; $display("FAIL reset_status got=%0d exp=%0d", status_register, ST_IDLE); end
    vectors++;
    if (data_o_register !== 32'h0) begin miscompares++; $display("FAIL reset_data_o got=%h exp=%h", data_o_register, 32'h0); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_elapsed got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_write_read;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'hA5A5_0001; exp_w[1] = 32'h5A5A_0002;
    exp_w[2] = 32'hDEAD_BEEF; exp_w[3] = 32'h0123_4567;
    for (int i = 0; i < 4; i++) blk[i] = exp_w[i];
    write_block(0, 4);
    // Held read: address k applied before posedge k, data_o shows it after posedge k+1.
    cmd_register = C_READ;
    for (int k = 0; k < 5; k++) begin
      address_register = (k < 4) ? k : 3;
      tick();
      if (k >= 1) begin
        vectors++;
        if (data_o_register !== exp_w[k-1]) begin
          miscompares++;
          $display("FAIL held_read[%0d] got=%h exp=%h", k - 1, data_o_register, exp_w[k-1]);
        end
      end
    end
    cmd_register = C_NOP;
  endtask

  task automatic test_accept;
    logic [31:0] st, d;
    load_regex_program();
    blk[0] = 32'h6263_6261;  // "abcb" at byte 64
    write_block(16, 1);
    start_run(64, 67, st);
    vectors++;
    if (st !== ST_RUN) begin miscompares++; $display("FAIL accept_running got=%0d exp=%0d", st, ST_RUN); end
    wait_done(st);
    vectors++;
    if (st !== ST_ACC) begin miscompares++; $display("FAIL accept_status got=%0d exp=%0d", st, ST_ACC); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd38) begin miscompares++; $display("FAIL accept_elapsed got=%0d exp=%0d", d, 38); end
  endtask

  task automatic test_cmd_reset;
    logic [31:0] d;
    soft_reset();
    vectors++;
    if (status_register !== ST_IDLE) begin miscompares++; $display("FAIL cmd_reset_status got=%0d exp=%0d", status_register, ST_IDLE); end
    read_word(0, d);
    vectors++;
    if (d !== 32'h2007_4061) begin miscompares++; $display("FAIL cmd_reset_mem0 got=%h exp=%h", d, 32'h2007_4061); end
    read_word(3, d);
    vectors++;
    if (d !== 32'h0000_6001) begin miscompares++; $display("FAIL cmd_reset_mem3 got=%h exp=%h", d, 32'h0000_6001); end
  endtask

  task automatic test_reject;
    logic [31:0] st, d;
    blk[0] = 32'h0064_6261;  // "abd"
    write_block(16, 1);
    start_run(64, 66, st);
    wait_done(st);
    vectors++;
    if (st !== ST_REJ) begin miscompares++; $display("FAIL reject_status got=%0d exp=%0d", st, ST_REJ); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd24) begin miscompares++; $display("FAIL reject_elapsed got=%0d exp=%0d", d, 24); end
    tick();
    tick();
    vectors++;
    if (data_o_register !== 32'd24) begin miscompares++; $display("FAIL data_o_hold got=%0d exp=%0d", data_o_register, 24); end
    soft_reset();
  endtask

  task automatic test_overflow;
    logic [31:0] st, d;
    blk[0] = 32'h1234_5678;
    write_block(100, 1);
    for (int i = 0; i < 8; i++) blk[i] = 32'h2014_2014;
    blk[8] = 32'h0000_2014;  // 17 SPLITs total
    write_block(0, 9);
    start_run(64, 67, st);
    // Host writes and reads during the run must have no effect.
    cmd_register = C_WRITE;
    address_register = 100;
    data_in_register = 32'hDEAD_DEAD;
    tick();
    cmd_register = C_READ;
    address_register = 0;
    tick();
    tick();
    cmd_register = C_NOP;
    vectors++;
    if (data_o_register !== 32'd24) begin miscompares++; $display("FAIL read_while_running got=%h exp=%h", data_o_register, 32'd24); end
    wait_done(st);
    vectors++;
    if (st !== ST_ERR) begin miscompares++; $display("FAIL overflow_status got=%0d exp=%0d", st, ST_ERR); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd34) begin miscompares++; $display("FAIL overflow_elapsed got=%0d exp=%0d", d, 34); end
    soft_reset();
    read_word(100, d);
    vectors++;
    if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL write_while_running got=%h exp=%h", d, 32'h1234_5678); end
  endtask

  task automatic test_rst_midrun;
    logic [31:0] st, d;
    start_run(64, 67, st);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (status_register !== ST_IDLE) begin miscompares++; $display("FAIL rst_midrun_status got=%0d exp=%0d", status_register, ST_IDLE); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL rst_midrun_elapsed got=%0d exp=%0d", d, 0); end
    start_run(64, 67, st);
    vectors++;
    if (st !== ST_RUN) begin miscompares++; $display("FAIL restart_running got=%0d exp=%0d", st, ST_RUN); end
    wait_done(st);
    vectors++;
    if (st !== ST_ERR) begin miscompares++; $display("FAIL restart_status got=%0d exp=%0d", st, ST_ERR); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd34) begin miscompares++; $display("FAIL restart_elapsed got=%0d exp=%0d", d, 34); end
    soft_reset();
  endtask

  task automatic test_ops_empty;
    logic [31:0] st, d;
    // 0 NOT_MATCH 'x'; 1 MATCH_ANY; 2 ACCEPT_PARTIAL
    blk[0] = 32'hA000_E078;
    blk[1] = 32'h0000_C000;
    write_block(0, 2);
    blk[0] = 32'h0000_6261;  // "ab"
    write_block(16, 1);
    start_run(64, 65, st);
    wait_done(st);
    vectors++;
    if (st !== ST_ACC) begin miscompares++; $display("FAIL ops_status got=%0d exp=%0d", st, ST_ACC); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd6) begin miscompares++; $display("FAIL ops_elapsed got=%0d exp=%0d", d, 6); end
    soft_reset();
    start_run(64, 63, st);  // empty string: NOT_MATCH fails
    wait_done(st);
    vectors++;
    if (st !== ST_REJ) begin miscompares++; $display("FAIL empty_not_match got=%0d exp=%0d", st, ST_REJ); end
    soft_reset();
    blk[0] = 32'h0000_0000;  // pc0 ACCEPT
    write_block(0, 1);
    start_run(64, 63, st);
    wait_done(st);
    vectors++;
    if (st !== ST_ACC) begin miscompares++; $display("FAIL empty_accept got=%0d exp=%0d", st, ST_ACC); end
    read_elapsed(d);
    vectors++;
    if (d !== 32'd2) begin miscompares++; $display("FAIL empty_accept_elapsed got=%0d exp=%0d", d, 2); end
    soft_reset();
    start_run(64, 64, st);  // one char left unconsumed: ACCEPT fails
    wait_done(st);
    vectors++;
    if (st !== ST_REJ) begin miscompares++; $display("FAIL accept_not_at_end got=%0d exp=%0d", st, ST_REJ); end
    soft_reset();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_accept();
    test_cmd_reset();
    test_reject();
    test_overflow();
    test_rst_midrun();
    test_ops_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
